// File: rtl/console_io_hub_pkg.sv
// console_io_hub_pkg: shared types and helpers for the console I/O hub.
// Holds the event-channel FSM encoding, the drop counter width and a
// saturating add used by the optional drop counter.
package console_io_hub_pkg;

  typedef enum logic [0:0] {
    EV_IDLE  = 1'b0,
    EV_OFFER = 1'b1
  } ev_state_e;

  localparam int DROP_W = 8;
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  // Add inc to count, clamping at the all-ones maximum.
  function automatic logic [DROP_W-1:0] drop_sat_add(input logic [DROP_W-1:0] count,
                                                     input int unsigned inc);
    int unsigned sum;
    sum = 32'(count) + inc;
    if (sum > 32'(DROP_MAX)) begin
      return DROP_MAX;
    end else begin
      return DROP_W'(sum);
    end
  endfunction

endpackage

// File: rtl/console_io_hub_event_rr_arbiter.sv
// console_io_hub_event_rr_arbiter: combinational round-robin scan.
// Starting one past rr_ptr and wrapping modulo NUM_EVENTS, reports whether
// any pending bit is set and the index of the first one found.
module console_io_hub_event_rr_arbiter #(
  parameter int NUM_EVENTS = 4,
  parameter int ID_W       = 2
) (
  input  logic [NUM_EVENTS-1:0] pending,
  input  logic [ID_W-1:0]       rr_ptr,
  output logic                  any,
  output logic [ID_W-1:0]       index
);

  logic [ID_W-1:0] cand_s;

  // Scan upward from rr_ptr+1 and keep the first pending index.
  always_comb begin
    any    = 1'b0;
    index  = '0;
    cand_s = '0;
    for (int k = 1; k <= NUM_EVENTS; k++) begin
      cand_s = ID_W'((int'(rr_ptr) + k) % NUM_EVENTS);
      if (!any && pending[cand_s]) begin
        any   = 1'b1;
        index = cand_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/console_io_hub.sv
// console_io_hub: pin-side I/O registering plus an event hub that arbitrates
// NUM_EVENTS pulse sources into one request/ack channel.
// Optional feature macro: CONSOLE_IO_DROP_COUNT_EN enables the saturating
// dropped-event counter; without it drop_count is 0 and drop_clr is ignored.
module console_io_hub
  import console_io_hub_pkg::*;
#(
  parameter  int RAM_PINS   = 4,
  parameter  int IO_BITS    = 2,
  parameter  int NUM_EVENTS = 4,
  localparam int ID_W       = $clog2(NUM_EVENTS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [RAM_PINS-1:0]   pin_data_in,
  input  logic [IO_BITS-1:0]    pin_rx,
  input  logic                  sync_data,
  input  logic                  ppu_reset,
  input  logic [RAM_PINS-1:0]   core_addr,
  output logic [RAM_PINS-1:0]   core_data,
  output logic [IO_BITS-1:0]    core_rx,
  output logic [RAM_PINS-1:0]   pin_addr,
  input  logic [NUM_EVENTS-1:0] event_pulse,
  input  logic [NUM_EVENTS-1:0] event_en,
  output logic                  ev_req,
  output logic [ID_W-1:0]       ev_id,
  input  logic                  ev_ack,
  input  logic                  drop_clr,
  output logic [DROP_W-1:0]     drop_count
);

  // ---------------- pin path ----------------
  logic [RAM_PINS-1:0] data_r;
  logic [IO_BITS-1:0]  rx_r;
  logic [RAM_PINS-1:0] pin_addr_r;

  // While the PPU is held in reset the data pins are looped back onto the
  // address pins so the RAM sees a defined address.
  assign core_data = sync_data ? data_r : pin_data_in;
  assign core_rx   = rx_r;
  assign pin_addr  = pin_addr_r;

  // Register raw data/RX pins and the outgoing address pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_r     <= '0;
      rx_r       <= '0;
      pin_addr_r <= '0;
    end else begin
      data_r     <= pin_data_in;
      rx_r       <= pin_rx;
      pin_addr_r <= ppu_reset ? core_data : core_addr;
    end
  end

  // ---------------- event hub ----------------
  ev_state_e             state_r, state_nxt_s;
  logic [ID_W-1:0]       ev_id_r, ev_id_nxt_s;
  logic [ID_W-1:0]       rr_ptr_r, rr_ptr_nxt_s;
  logic [NUM_EVENTS-1:0] pending_r;
  logic [NUM_EVENTS-1:0] clr_s;
  logic                  ev_req_s;
  logic                  arb_any_s;
  logic [ID_W-1:0]       arb_index_s;

  assign ev_req_s = (state_r == EV_OFFER);
  assign ev_req   = ev_req_s;
  assign ev_id    = ev_id_r;

  // One-hot clear of the pending bit being accepted this cycle.
  always_comb begin
    clr_s = '0;
    if (ev_req_s && ev_ack) begin
      clr_s[ev_id_r] = 1'b1;
    end else begin
      clr_s = '0;
    end
  end

  // Pending bits: a pulse sets, an accepted offer clears (a coincident pulse
  // wins, counting as a new occurrence), and disabling drops the bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= '0;
    end else begin
      pending_r <= event_en & ((pending_r & ~clr_s) | event_pulse);
    end
  end

  console_io_hub_event_rr_arbiter #(
    .NUM_EVENTS (NUM_EVENTS),
    .ID_W       (ID_W)
  ) u_arb (
    .pending (pending_r),
    .rr_ptr  (rr_ptr_r),
    .any     (arb_any_s),
    .index   (arb_index_s)
  );

  // Offer FSM state, latched id and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= EV_IDLE;
      ev_id_r  <= '0;
      rr_ptr_r <= ID_W'(NUM_EVENTS - 1);
    end else begin
      state_r  <= state_nxt_s;
      ev_id_r  <= ev_id_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
    end
  end

  // Offer FSM: grant from IDLE, finish on ack, withdraw if the bit vanished.
  always_comb begin
    state_nxt_s  = state_r;
    ev_id_nxt_s  = ev_id_r;
    rr_ptr_nxt_s = rr_ptr_r;
    case (state_r)
      EV_IDLE: begin
        if (arb_any_s) begin
          state_nxt_s = EV_OFFER;
          ev_id_nxt_s = arb_index_s;
        end else begin
          state_nxt_s = EV_IDLE;
        end
      end
      EV_OFFER: begin
        if (ev_ack) begin
          state_nxt_s  = EV_IDLE;
          rr_ptr_nxt_s = ev_id_r;
        end else if (!pending_r[ev_id_r]) begin
          state_nxt_s = EV_IDLE;
        end else begin
          state_nxt_s = EV_OFFER;
        end
      end
      default: begin
        state_nxt_s = EV_IDLE;
      end
    endcase
  end

  // ---------------- drop counter ----------------
`ifdef CONSOLE_IO_DROP_COUNT_EN
  logic [NUM_EVENTS-1:0] drop_s;
  logic [DROP_W-1:0]     drop_count_r;

  // A pulse landing on a still-pending, enabled, not-being-cleared bit is lost.
  assign drop_s     = event_pulse & pending_r & ~clr_s & event_en;
  assign drop_count = drop_count_r;

  // Saturating count of lost pulses; a clear wins over same-cycle drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count_r <= '0;
    end else if (drop_clr) begin
      drop_count_r <= '0;
    end else begin
      drop_count_r <= drop_sat_add(drop_count_r, unsigned'($countones(drop_s)));
    end
  end
`else
  logic unused_drop_clr_s;
  assign unused_drop_clr_s = drop_clr;
  assign drop_count        = '0;
`endif

endmodule

// File: tb/tb_console_io_hub.sv
// tb_console_io_hub: directed scenarios plus randomized traffic for
// console_io_hub, checked against a transaction-level model of the hub.
module tb_console_io_hub;

  localparam int RP = 4;
  localparam int IB = 2;
  localparam int NE = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [RP-1:0] pin_data_in = '0;
  logic [IB-1:0] pin_rx = '0;
  logic          sync_data = 1'b0;
  logic          ppu_reset = 1'b0;
  logic [RP-1:0] core_addr = '0;
  logic [RP-1:0] core_data;
  logic [IB-1:0] core_rx;
  logic [RP-1:0] pin_addr;
  logic [NE-1:0] event_pulse = '0;
  logic [NE-1:0] event_en = '0;
  logic          ev_req;
  logic [IW-1:0] ev_id;
  logic          ev_ack = 1'b0;
  logic          drop_clr = 1'b0;
  logic [7:0]    drop_count;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  bit m_pend[NE];
  bit m_req;
  int m_id;
  int m_rr;
  int m_cnt;
  int m_data;
  int m_rx;
  int m_addr;

  int g_ids[4];
  int g_got;

  console_io_hub dut (
    .clk         (clk),
    .reset       (reset),
    .pin_data_in (pin_data_in),
    .pin_rx      (pin_rx),
    .sync_data   (sync_data),
    .ppu_reset   (ppu_reset),
    .core_addr   (core_addr),
    .core_data   (core_data),
    .core_rx     (core_rx),
    .pin_addr    (pin_addr),
    .event_pulse (event_pulse),
    .event_en    (event_en),
    .ev_req      (ev_req),
    .ev_id       (ev_id),
    .ev_ack      (ev_ack),
    .drop_clr    (drop_clr),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  // Advance the model by one clock using the inputs present at the edge,
  // then let the DUT take the same edge and settle.
  task automatic tick();
    int  clr_id;
    int  drops;
    int  idx;
    bit  np[NE];
    bit  found;
    if (reset) begin
      for (int i = 0; i < NE; i++) m_pend[i] = 1'b0;
      m_req = 1'b0; m_id = 0; m_rr = NE - 1; m_cnt = 0;
      m_data = 0; m_rx = 0; m_addr = 0;
    end else begin
      clr_id = (m_req && ev_ack) ? m_id : -1;
      drops = 0;
      for (int i = 0; i < NE; i++) begin
        if (event_pulse[i] && m_pend[i] && clr_id != i && event_en[i]) drops++;
        np[i] = event_en[i] && ((m_pend[i] && clr_id != i) || event_pulse[i]);
      end
`ifdef CONSOLE_IO_DROP_COUNT_EN
      if (drop_clr) m_cnt = 0;
      else m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
`else
      m_cnt = 0;
`endif
      if (m_req) begin
        if (ev_ack) begin
          m_req = 1'b0;
          m_rr = m_id;
        end else if (!m_pend[m_id]) begin
          m_req = 1'b0;
        end
      end else begin
        found = 1'b0;
        for (int k = 1; k <= NE; k++) begin
          idx = (m_rr + k) % NE;
          if (!found && m_pend[idx]) begin
            found = 1'b1;
            m_req = 1'b1;
            m_id = idx;
          end
        end
      end
      m_addr = ppu_reset ? (sync_data ? m_data : int'(pin_data_in)) : int'(core_addr);
      m_data = int'(pin_data_in);
      m_rx = int'(pin_rx);
      for (int i = 0; i < NE; i++) m_pend[i] = np[i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    event_pulse = '0; event_en = '0; ev_ack = 1'b0; drop_clr = 1'b0;
    ppu_reset = 1'b0; sync_data = 1'b0; pin_data_in = '0; pin_rx = '0; core_addr = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait for up to n offers, acking each as soon as it is seen.
  task automatic collect_grants(input int n);
    g_got = 0;
    for (int c = 0; c < 40 && g_got < n; c++) begin
      if (ev_req) begin
        g_ids[g_got] = int'(ev_id);
        g_got++;
        ev_ack = 1'b1;
        tick();
        ev_ack = 1'b0;
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    sync_data = 1'b1;
    #1;
    n_cmp += 6;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL reset_ev_req: got %0b expected 0", ev_req); end
    if (ev_id !== 2'd0) begin n_bad++; $display("FAIL reset_ev_id: got %0d expected 0", ev_id); end
    if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reset_drop: got %0d expected 0", drop_count); end
    if (pin_addr !== 4'd0) begin n_bad++; $display("FAIL reset_pin_addr: got %0h expected 0", pin_addr); end
    if (core_rx !== 2'd0) begin n_bad++; $display("FAIL reset_core_rx: got %0h expected 0", core_rx); end
    if (core_data !== 4'd0) begin n_bad++; $display("FAIL reset_core_data: got %0h expected 0", core_data); end
  endtask

  task automatic test_single_event();
    do_reset();
    event_en = 4'hF;
    event_pulse = 4'b0100;
    tick();
    event_pulse = '0;
    n_cmp++;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL single_early: got ev_req=%0b expected 0", ev_req); end
    tick();
    n_cmp++;
    if (ev_req !== 1'b1 || ev_id !== 2'd2) begin
      n_bad++; $display("FAIL single_offer: got req=%0b id=%0d expected req=1 id=2", ev_req, ev_id);
    end
    ev_ack = 1'b1;
    tick();
    ev_ack = 1'b0;
    n_cmp++;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL single_bubble: got ev_req=%0b expected 0", ev_req); end
    tick();
    tick();
    n_cmp++;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL single_cleared: got ev_req=%0b expected 0", ev_req); end
  endtask

  task automatic test_round_robin();
    int exp_a[3];
    int exp_b[3];
    exp_a = '{0, 1, 3};
    exp_b = '{3, 0, 1};
    do_reset();
    event_en = 4'hF;
    event_pulse = 4'b1011;
    tick();
    event_pulse = '0;
    collect_grants(3);
    n_cmp++;
    if (g_got != 3) begin n_bad++; $display("FAIL rr_a_count: got %0d grants expected 3", g_got); end
    for (int i = 0; i < g_got && i < 3; i++) begin
      n_cmp++;
      if (g_ids[i] != exp_a[i]) begin n_bad++; $display("FAIL rr_a_order[%0d]: got %0d expected %0d", i, g_ids[i], exp_a[i]); end
    end
    tick();
    tick();
    n_cmp++;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL rr_idle: got ev_req=%0b expected 0", ev_req); end
    event_pulse = 4'b0010;
    tick();
    event_pulse = '0;
    collect_grants(1);
    n_cmp++;
    if (g_got != 1 || g_ids[0] != 1) begin n_bad++; $display("FAIL rr_single1: got %0d grants id %0d expected 1 grant id 1", g_got, g_ids[0]); end
    event_pulse = 4'b1011;
    tick();
    event_pulse = '0;
    collect_grants(3);
    n_cmp++;
    if (g_got != 3) begin n_bad++; $display("FAIL rr_b_count: got %0d grants expected 3", g_got); end
    for (int i = 0; i < g_got && i < 3; i++) begin
      n_cmp++;
      if (g_ids[i] != exp_b[i]) begin n_bad++; $display("FAIL rr_b_order[%0d]: got %0d expected %0d", i, g_ids[i], exp_b[i]); end
    end
  endtask

  task automatic test_reoffer();
    do_reset();
    event_en = 4'hF;
    event_pulse = 4'b0010;
    tick();
    event_pulse = '0;
    tick();
    n_cmp++;
    if (ev_req !== 1'b1 || ev_id !== 2'd1) begin n_bad++; $display("FAIL reoffer_first: got req=%0b id=%0d expected req=1 id=1", ev_req, ev_id); end
    ev_ack = 1'b1;
    event_pulse = 4'b0010;
    tick();
    ev_ack = 1'b0;
    event_pulse = '0;
    n_cmp++;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL reoffer_bubble: got ev_req=%0b expected 0", ev_req); end
    tick();
    n_cmp += 2;
    if (ev_req !== 1'b1 || ev_id !== 2'd1) begin n_bad++; $display("FAIL reoffer_again: got req=%0b id=%0d expected req=1 id=1", ev_req, ev_id); end
    if (drop_count !== 8'd0) begin n_bad++; $display("FAIL reoffer_drop: got %0d expected 0", drop_count); end
    ev_ack = 1'b1;
    tick();
    ev_ack = 1'b0;
  endtask

  task automatic test_withdraw();
    do_reset();
    event_en = 4'hF;
    event_pulse = 4'b0001;
    tick();
    event_pulse = '0;
    tick();
    n_cmp++;
    if (ev_req !== 1'b1 || ev_id !== 2'd0) begin n_bad++; $display("FAIL withdraw_offer: got req=%0b id=%0d expected req=1 id=0", ev_req, ev_id); end
    event_en = 4'b1110;
    tick();
    n_cmp++;
    if (ev_req !== 1'b1) begin n_bad++; $display("FAIL withdraw_hold: got ev_req=%0b expected 1", ev_req); end
    tick();
    n_cmp++;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL withdraw_drop: got ev_req=%0b expected 0", ev_req); end
    event_en = 4'hF;
    tick();
    tick();
    n_cmp++;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL withdraw_pending_lost: got ev_req=%0b expected 0", ev_req); end
  endtask

  task automatic test_drop_saturate();
    logic [7:0] exp_cnt;
`ifdef CONSOLE_IO_DROP_COUNT_EN
    exp_cnt = 8'd255;
`else
    exp_cnt = 8'd0;
`endif
    do_reset();
    event_en = 4'hF;
    for (int i = 0; i < 300; i++) begin
      event_pulse = 4'b1000;
      tick();
    end
    event_pulse = '0;
    n_cmp += 2;
    if (drop_count !== exp_cnt) begin n_bad++; $display("FAIL drop_saturate: got %0d expected %0d", drop_count, exp_cnt); end
    if (ev_req !== 1'b1 || ev_id !== 2'd3) begin n_bad++; $display("FAIL drop_offer: got req=%0b id=%0d expected req=1 id=3", ev_req, ev_id); end
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    n_cmp++;
    if (drop_count !== 8'd0) begin n_bad++; $display("FAIL drop_clear: got %0d expected 0", drop_count); end
    ev_ack = 1'b1;
    tick();
    ev_ack = 1'b0;
  endtask

  task automatic test_pins();
    do_reset();
    ppu_reset = 1'b1;
    sync_data = 1'b1;
    pin_data_in = 4'hA;
    tick();
    tick();
    n_cmp++;
    if (pin_addr !== 4'hA) begin n_bad++; $display("FAIL pins_loopback: got %0h expected a", pin_addr); end
    ppu_reset = 1'b0;
    core_addr = 4'h5;
    tick();
    n_cmp++;
    if (pin_addr !== 4'h5) begin n_bad++; $display("FAIL pins_addr: got %0h expected 5", pin_addr); end
    pin_rx = 2'b10;
    tick();
    pin_data_in = 4'h3;
    sync_data = 1'b0;
    #1;
    n_cmp += 2;
    if (core_rx !== 2'b10) begin n_bad++; $display("FAIL pins_rx: got %0h expected 2", core_rx); end
    if (core_data !== 4'h3) begin n_bad++; $display("FAIL pins_raw: got %0h expected 3", core_data); end
    sync_data = 1'b1;
    #1;
    n_cmp++;
    if (core_data !== 4'hA) begin n_bad++; $display("FAIL pins_sync: got %0h expected a", core_data); end
  endtask

  task automatic test_reset_mid_offer();
    do_reset();
    event_en = 4'hF;
    event_pulse = 4'b0101;
    tick();
    event_pulse = '0;
    tick();
    n_cmp++;
    if (ev_req !== 1'b1) begin n_bad++; $display("FAIL midreset_offer: got ev_req=%0b expected 1", ev_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (ev_req !== 1'b0 || ev_id !== 2'd0) begin n_bad++; $display("FAIL midreset_drop: got req=%0b id=%0d expected req=0 id=0", ev_req, ev_id); end
    tick();
    tick();
    n_cmp++;
    if (ev_req !== 1'b0) begin n_bad++; $display("FAIL midreset_lost: got ev_req=%0b expected 0", ev_req); end
  endtask

  task automatic test_random();
    logic [RP-1:0] exp_cd;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NE; i++) event_pulse[i] = ($urandom_range(0, 3) == 0);
      event_en = ($urandom_range(0, 7) == 0) ? NE'($urandom) : 4'hF;
      ev_ack = 1'($urandom);
      drop_clr = ($urandom_range(0, 15) == 0);
      pin_data_in = RP'($urandom);
      pin_rx = IB'($urandom);
      core_addr = RP'($urandom);
      sync_data = 1'($urandom);
      ppu_reset = 1'($urandom);
      tick();
      exp_cd = sync_data ? RP'(m_data) : pin_data_in;
      n_cmp += 6;
      if (ev_req !== m_req) begin n_bad++; $display("FAIL rand_ev_req@%0d: got %0b expected %0b", c, ev_req, m_req); end
      if (ev_id !== IW'(m_id)) begin n_bad++; $display("FAIL rand_ev_id@%0d: got %0d expected %0d", c, ev_id, m_id); end
      if (drop_count !== 8'(m_cnt)) begin n_bad++; $display("FAIL rand_drop@%0d: got %0d expected %0d", c, drop_count, m_cnt); end
      if (pin_addr !== RP'(m_addr)) begin n_bad++; $display("FAIL rand_pin_addr@%0d: got %0h expected %0h", c, pin_addr, m_addr); end
      if (core_rx !== IB'(m_rx)) begin n_bad++; $display("FAIL rand_core_rx@%0d: got %0h expected %0h", c, core_rx, m_rx); end
      if (core_data !== exp_cd) begin n_bad++; $display("FAIL rand_core_data@%0d: got %0h expected %0h", c, core_data, exp_cd); end
    end
    ev_ack = 1'b0;
    drop_clr = 1'b0;
    event_pulse = '0;
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_round_robin();
    test_reoffer();
    test_withdraw();
    test_drop_saturate();
    test_pins();
    test_reset_mid_offer();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
